// File: rtl/sound_comm_if.sv
// Bus bundle between the M68K sound-latch decode, the Z80 I/O decode and sound_comm.
// The slave modport is the sound_comm side; master is the CPU/decode side.
interface sound_comm_if;
    logic       z80_clk_en;
    logic       sound_latch_cs;
    logic       m68k_rw_n;
    logic       m68k_lds_n;
    logic [7:0] m68k_din;
    logic       z80_latch_r_cs;
    logic       z80_latch_clr_cs;
    logic       z80_rd_n;
    logic       z80_wr_n;
    logic       M1_n;
    logic       IORQ_n;
    logic [7:0] z80_dout;
    logic       z80_dout_en;
    logic       z80_int_n;
    logic       latch_full;

    modport slave (
        input  z80_clk_en,
        input  sound_latch_cs,
        input  m68k_rw_n,
        input  m68k_lds_n,
        input  m68k_din,
        input  z80_latch_r_cs,
        input  z80_latch_clr_cs,
        input  z80_rd_n,
        input  z80_wr_n,
        input  M1_n,
        input  IORQ_n,
        output z80_dout,
        output z80_dout_en,
        output z80_int_n,
        output latch_full
    );

    modport master (
        output z80_clk_en,
        output sound_latch_cs,
        output m68k_rw_n,
        output m68k_lds_n,
        output m68k_din,
        output z80_latch_r_cs,
        output z80_latch_clr_cs,
        output z80_rd_n,
        output z80_wr_n,
        output M1_n,
        output IORQ_n,
        input  z80_dout,
        input  z80_dout_en,
        input  z80_int_n,
        input  latch_full
    );
endinterface

// File: rtl/sound_comm.sv
// M68K -> Z80 sound command latch with full flag, plus the Z80 periodic timer interrupt.
// Bus strobes are edge-detected so a strobe held for several clk_sys cycles acts once.
module sound_comm #(
    parameter int TIMER_DIV = 512
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    sound_comm_if.slave  bus
);

    localparam int            TW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMER_DIV - 1);

    logic [7:0]    latch;
    logic          latch_full_q;
    logic [TW-1:0] timer;
    logic          irq_pending;
    logic          int_n_q;

    logic wr_prev;
    logic clr_prev;
    logic ack_prev;

    logic wr_term;
    logic clr_term;
    logic ack_term;
    logic wr_det;
    logic clr_det;
    logic ack_det;
    logic tick;
    logic irq_next;

    assign wr_term  = bus.sound_latch_cs & ~bus.m68k_rw_n & ~bus.m68k_lds_n;
    assign clr_term = bus.z80_latch_clr_cs & ~bus.z80_wr_n;
    assign ack_term = ~bus.M1_n & ~bus.IORQ_n;

    assign wr_det   = wr_term  & ~wr_prev;
    assign clr_det  = clr_term & ~clr_prev;
    assign ack_det  = ack_term & ~ack_prev;

    assign tick     = bus.z80_clk_en & (timer == TIMER_MAX);
    // A tick outranks a coincident acknowledge so that interrupt is never lost.
    assign irq_next = tick | (irq_pending & ~ack_det);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            latch        <= 8'h00;
            latch_full_q <= 1'b0;
            timer        <= '0;
            irq_pending  <= 1'b0;
            int_n_q      <= 1'b1;
            wr_prev      <= 1'b0;
            clr_prev     <= 1'b0;
            ack_prev     <= 1'b0;
        end else begin
            wr_prev  <= wr_term;
            clr_prev <= clr_term;
            ack_prev <= ack_term;

            // The 68K write wins over a same-cycle Z80 clear.
            if (wr_det) begin
                latch        <= bus.m68k_din;
                latch_full_q <= 1'b1;
            end else if (clr_det) begin
                latch        <= 8'h00;
                latch_full_q <= 1'b0;
            end

            if (bus.z80_clk_en) begin
                timer <= tick ? '0 : timer + TW'(1);
            end

            irq_pending <= irq_next;
            int_n_q     <= ~irq_next;
        end
    end

    assign bus.z80_dout    = latch;
    assign bus.z80_dout_en = bus.z80_latch_r_cs & ~bus.z80_rd_n;
    assign bus.z80_int_n   = int_n_q;
    assign bus.latch_full  = latch_full_q;

endmodule
